// File: rtl/loba_seq_mul_pkg.sv
// Shared types for the sequential LOBA multiplier: FSM states and width helpers.
package loba_seq_mul_pkg;

  localparam int LOBA_N_DEF = 16;
  localparam int LOBA_K_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPLIT = 3'd1,
    ST_MAC0  = 3'd2,
    ST_MAC1  = 3'd3,
    ST_MAC2  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Width of a shift amount able to address any bit of a 2n-bit product.
  function automatic int shift_w(input int n);
    return $clog2(2 * n);
  endfunction

  // Width of a segment index inside an n-bit operand.
  function automatic int index_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/loba_split_comb.sv
// Combinational LOBA split of one operand into a high and a low K-bit segment
// with their shift positions.
module loba_split_comb
  import loba_seq_mul_pkg::*;
#(
  parameter int N  = LOBA_N_DEF,
  parameter int K  = LOBA_K_DEF,
  parameter int IW = index_w(LOBA_N_DEF)
) (
  input  logic [N-1:0]  x,
  output logic [K-1:0]  xh,
  output logic [IW-1:0] kh,
  output logic [K-1:0]  xl,
  output logic [IW-1:0] kl
);

  // Position that places the leading one at the top of a K-bit window;
  // values whose leading one sits below bit K-1 are not shifted at all.
  function automatic logic [IW-1:0] seg_shift(input logic [N-1:0] v);
    logic [IW-1:0] s;
    s = '0;
    for (int i = K - 1; i < N; i++) begin
      if (v[i]) s = IW'(i - (K - 1));
    end
    return s;
  endfunction

  logic [N-1:0] rem;

  always_comb begin
    kh  = seg_shift(x);
    xh  = K'(x >> kh);
    rem = x - (N'(xh) << kh);
    kl  = seg_shift(rem);
    xl  = K'(rem >> kl);
  end

endmodule

// File: rtl/loba_seq_mul.sv
// Area-reduced LOBA approximate multiplier: one KxK multiplier and one shifter
// are reused over three MAC cycles to accumulate the LOBA partial products.
module loba_seq_mul
  import loba_seq_mul_pkg::*;
#(
  parameter int N = LOBA_N_DEF,
  parameter int K = LOBA_K_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P,
  output logic           busy
);

  localparam int SW = shift_w(N);
  localparam int IW = index_w(N);
  localparam int PW = 2 * N;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [K-1:0]   ah_q, ah_d, al_q, al_d, bh_q, bh_d, bl_q, bl_d;
  logic [IW-1:0]  kha_q, kha_d, kla_q, kla_d, khb_q, khb_d, klb_q, klb_d;
  logic [PW-1:0]  acc_q, acc_d;

  logic [K-1:0]   sa_h, sa_l, sb_h, sb_l;
  logic [IW-1:0]  sa_kh, sa_kl, sb_kh, sb_kl;

  loba_split_comb #(.N(N), .K(K), .IW(IW)) u_split_a (
    .x (a_q),
    .xh(sa_h),
    .kh(sa_kh),
    .xl(sa_l),
    .kl(sa_kl)
  );

  loba_split_comb #(.N(N), .K(K), .IW(IW)) u_split_b (
    .x (b_q),
    .xh(sb_h),
    .kh(sb_kh),
    .xl(sb_l),
    .kl(sb_kl)
  );

  // Shared datapath: the MAC state picks which segment pair and shift to use.
  logic [K-1:0]   mul_a, mul_b;
  logic [SW-1:0]  sh_amt;
  logic [2*K-1:0] prod;
  logic [PW-1:0]  prod_sh;

  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    sh_amt = '0;
    case (state_q)
      ST_MAC0: begin
        mul_a  = ah_q;
        mul_b  = bh_q;
        sh_amt = SW'(kha_q) + SW'(khb_q);
      end
      ST_MAC1: begin
        mul_a  = ah_q;
        mul_b  = bl_q;
        sh_amt = SW'(kha_q) + SW'(klb_q);
      end
      ST_MAC2: begin
        mul_a  = al_q;
        mul_b  = bh_q;
        sh_amt = SW'(kla_q) + SW'(khb_q);
      end
      default: ;
    endcase
    prod    = (2*K)'(mul_a) * (2*K)'(mul_b);
    prod_sh = PW'(prod) << sh_amt;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ah_d    = ah_q;
    al_d    = al_q;
    bh_d    = bh_q;
    bl_d    = bl_q;
    kha_d   = kha_q;
    kla_d   = kla_q;
    khb_d   = khb_q;
    klb_d   = klb_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          state_d = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        ah_d    = sa_h;
        al_d    = sa_l;
        kha_d   = sa_kh;
        kla_d   = sa_kl;
        bh_d    = sb_h;
        bl_d    = sb_l;
        khb_d   = sb_kh;
        klb_d   = sb_kl;
        state_d = ST_MAC0;
      end
      ST_MAC0: begin
        acc_d   = acc_q + prod_sh;
        state_d = ST_MAC1;
      end
      ST_MAC1: begin
        acc_d   = acc_q + prod_sh;
        state_d = ST_MAC2;
      end
      ST_MAC2: begin
        acc_d   = acc_q + prod_sh;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ah_q    <= '0;
      al_q    <= '0;
      bh_q    <= '0;
      bl_q    <= '0;
      kha_q   <= '0;
      kla_q   <= '0;
      khb_q   <= '0;
      klb_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ah_q    <= ah_d;
      al_q    <= al_d;
      bh_q    <= bh_d;
      bl_q    <= bl_d;
      kha_q   <= kha_d;
      kla_q   <= kla_d;
      khb_q   <= khb_d;
      klb_q   <= klb_d;
      acc_q   <= acc_d;
    end
  end

  // All handshake outputs come straight from registered state.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign P         = acc_q;

endmodule
